wino_tile_sched: RTL and testbench
==================================

WINO_TILE_SCHED -- requirements
Module: wino_tile_sched

Interface
REQ-001 Parameter DIMW, default 8: width of feature-map dimension and coordinate fields.
REQ-002 Parameter KERN_LAT, default 3: cycles from kernel input accept to Y valid; legal range 1..8.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to begin a layer; honoured only in IDLE.
REQ-007 abort  in  1  cancels the layer from any non-IDLE state.
REQ-008 cfg_h, cfg_w  in  DIMW each  input feature-map height/width, sampled on accepted start.
REQ-009 filt_ld  out  1  one-cycle pulse that latches the 9x8b filter into the Winograd kernel.
REQ-010 tile_req  out  1  request for the 4x4 input tile at (tile_row, tile_col).
REQ-011 tile_row, tile_col  out  DIMW each  top-left input coordinate of the requested tile.
REQ-012 tile_ack  in  1  tile buffer presents the 4x4 data tile to the kernel this cycle.
REQ-013 kern_vld  out  1  the kernel data input is valid this cycle; equals tile_req & tile_ack.
REQ-014 out_vld  out  1  the kernel Y output (2x2 result) is valid this cycle.
REQ-015 out_row, out_col  out  DIMW each  top-left output-map coordinate of the valid Y.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse at layer end.
REQ-018 err  out  1  sticky config error, cleared on next accepted start.

Function
REQ-019 States: IDLE, LOADF, RUN, DRAIN, DONE.
REQ-020 IDLE->LOADF on start when cfg_h, cfg_w are even and >=4; IDLE->DONE with err=1 otherwise.
REQ-021 LOADF lasts one cycle with filt_ld=1, then RUN.
REQ-022 RUN: tile_req=1; tile indices tr in 0..(H-2)/2-1, tc in 0..(W-2)/2-1, raster order, tc fastest.
REQ-023 tile_row=2*tr, tile_col=2*tc; indices advance only on tile_req & tile_ack; held otherwise.
REQ-024 On the handshake for the last tile, RUN->DRAIN; tile_req low from the next cycle.
REQ-025 A KERN_LAT-deep valid/coordinate shift register advances every cycle: out_vld, out_row=2*tr, out_col=2*tc appear exactly KERN_LAT cycles after the matching kern_vld.
REQ-026 Back-to-back acks produce back-to-back out_vld; ack gaps reproduce as out_vld gaps.
REQ-027 DRAIN->DONE on the cycle after the final out_vld; DONE lasts one cycle with done=1, then IDLE.
REQ-028 abort in LOADF/RUN/DRAIN: next state IDLE, shift-register valids cleared, done not pulsed; abort has priority over all other transitions.
REQ-029 start while busy is ignored; cfg is not resampled mid-layer.
REQ-030 Coordinate arithmetic uses DIMW bits; config guarantees no overflow.

Reset
REQ-031 While rstn=0: state IDLE; all counters, shift register, tile_*, out_*, filt_ld, kern_vld, out_vld, busy, done, err are 0.
REQ-032 Reset deassertion mid-layer restarts nothing; the block waits in IDLE for start.

Structure
REQ-033 Shared package wino_pkg holds the state enumeration, DIMW default and tile size constants (4 in, 2 out, stride 2).
REQ-034 One sub-module wino_lat_pipe: parameterised KERN_LAT-deep valid+coordinate delay line.

Verification
REQ-035 H=W=4, ack tied high: filt_ld at cycle 1, one kern_vld (0,0), out_vld (0,0) KERN_LAT cycles later, done next cycle.
REQ-036 H=6, W=8, ack high: tiles (0,0),(0,2),(0,4),(2,0),(2,2),(2,4) on consecutive cycles; six consecutive out_vld with same coords.
REQ-037 H=W=6, ack low 3 cycles after first tile: tile_row/col held at (0,2); out_vld gap of 3 cycles.
REQ-038 cfg_w=5: no filt_ld, no tile_req; done pulse with err=1; next valid start clears err.
REQ-039 abort asserted in DRAIN with 2 outputs in flight: no further out_vld, no done, IDLE next cycle.
REQ-040 rstn pulsed low mid-RUN: all outputs 0 asynchronously; start afterwards runs a full layer from (0,0).

Source files
------------

// File: rtl/wino_pkg.sv
// wino_pkg -- shared definitions for the Winograd tile scheduler.
//   state_t      : scheduler FSM states (also exported on the debug port)
//   DIMW_DEF     : default width of feature-map dimensions and coordinates
//   TILE_IN      : input tile edge (4x4 data tile)
//   TILE_OUT     : output tile edge (2x2 Y result)
//   TILE_STRIDE  : step between neighbouring tiles in the input map
//   dim_ok()     : a feature-map dimension is usable when even and >= TILE_IN
package wino_pkg;

  localparam int DIMW_DEF    = 8;
  localparam int TILE_IN     = 4;
  localparam int TILE_OUT    = 2;
  localparam int TILE_STRIDE = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADF = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic dim_ok(input logic [31:0] d);
    return (d[0] == 1'b0) && (d >= 32'(TILE_IN));
  endfunction

endpackage

// File: rtl/wino_tile_sched_if.sv
// wino_tile_sched_if -- kernel-side bus of the Winograd tile scheduler.
//   filt_ld            : one-cycle pulse latching the 3x3 filter into the kernel
//   tile_req           : scheduler requests the tile at (tile_row, tile_col)
//   tile_row, tile_col : top-left input coordinate of the requested tile
//   tile_ack           : tile buffer drives the tile into the kernel this cycle
//   kern_vld           : kernel data input valid (tile_req & tile_ack)
//   out_vld            : kernel Y output valid
//   out_row, out_col   : top-left output coordinate of the valid Y
//
// Handshake: tile_req is the valid, tile_ack the ready. A tile transfers on
// every rising edge where both are high; tile_row/tile_col stay stable while
// tile_req is high and no transfer has happened. tile_ack may be driven
// combinationally and may toggle freely; it has no effect while tile_req is low.
// out_vld has no back-pressure: every result is presented for exactly one cycle.
interface wino_tile_sched_if
  import wino_pkg::*;
#(
  parameter int DIMW = DIMW_DEF
);
  logic            filt_ld;
  logic            tile_req;
  logic [DIMW-1:0] tile_row;
  logic [DIMW-1:0] tile_col;
  logic            tile_ack;
  logic            kern_vld;
  logic            out_vld;
  logic [DIMW-1:0] out_row;
  logic [DIMW-1:0] out_col;

  modport master (
    output filt_ld, tile_req, tile_row, tile_col, kern_vld,
    output out_vld, out_row, out_col,
    input  tile_ack
  );

  modport slave (
    input  filt_ld, tile_req, tile_row, tile_col, kern_vld,
    input  out_vld, out_row, out_col,
    output tile_ack
  );
endinterface

// File: rtl/wino_lat_pipe.sv
// wino_lat_pipe -- LAT-deep delay line carrying a valid bit and a tile
// coordinate alongside the Winograd kernel, so each Y result leaves with the
// output coordinate of the tile that produced it.
//   clk, rstn          : clock, asynchronous active-low reset
//   flush              : clears every in-flight valid (the input included)
//   in_vld             : kernel input accepted this cycle
//   in_row, in_col     : coordinate travelling with that input
//   out_vld            : delayed valid, exactly LAT cycles after in_vld
//   out_row, out_col   : delayed coordinate
//   pend               : a valid is still in a stage before the output stage
module wino_lat_pipe #(
  parameter int DIMW = 8,
  parameter int LAT  = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_vld,
  input  logic [DIMW-1:0] in_row,
  input  logic [DIMW-1:0] in_col,
  output logic            out_vld,
  output logic [DIMW-1:0] out_row,
  output logic [DIMW-1:0] out_col,
  output logic            pend
);

  logic [LAT-1:0]  vld_sr;
  logic [DIMW-1:0] row_sr [LAT];
  logic [DIMW-1:0] col_sr [LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_sr <= '0;
      for (int i = 0; i < LAT; i++) begin
        row_sr[i] <= '0;
        col_sr[i] <= '0;
      end
    end else begin
      vld_sr[0] <= in_vld & ~flush;
      row_sr[0] <= in_row;
      col_sr[0] <= in_col;
      for (int i = 1; i < LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1] & ~flush;
        row_sr[i] <= row_sr[i-1];
        col_sr[i] <= col_sr[i-1];
      end
    end
  end

  // Stages short of the output: when none is valid, whatever is on out_vld
  // is the last result of the layer.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      pend = pend | vld_sr[i];
    end
  end

  assign out_vld = vld_sr[LAT-1];
  assign out_row = row_sr[LAT-1];
  assign out_col = col_sr[LAT-1];

endmodule

// File: rtl/wino_tile_sched.sv
// wino_tile_sched -- walks a HxW input feature map in 4x4 tiles with stride 2
// (raster order, column fastest), feeds them to a Winograd F(2x2,3x3) kernel
// and tags each kernel result with its 2x2 output coordinate.
//   clk, rstn      : clock, asynchronous active-low reset
//   start          : begin a layer (honoured in IDLE only)
//   abort          : cancel the layer from LOADF/RUN/DRAIN
//   cfg_h, cfg_w   : feature-map height/width, sampled on an accepted start
//   bus            : kernel-side bus (filter load, tile handshake, Y output)
//   busy           : high in every state except IDLE
//   done           : one-cycle pulse at layer end (also after a config error)
//   err            : sticky config error, cleared by the next accepted start
//   dbg_state      : current FSM state
module wino_tile_sched
  import wino_pkg::*;
#(
  parameter int DIMW     = DIMW_DEF,
  parameter int KERN_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DIMW-1:0]         cfg_h,
  input  logic [DIMW-1:0]         cfg_w,
  wino_tile_sched_if.master       bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output state_t                  dbg_state
);

  state_t          state, state_nxt;
  logic [DIMW-1:0] tr, tc;            // tile indices (row, column)
  logic [DIMW-1:0] tr_last, tc_last;  // last tile index of the layer
  logic            err_q;
  logic            cfg_good;
  logic            hs;
  logic            last_tile;
  logic            abort_hit;
  logic            pend;

  assign cfg_good  = dim_ok(32'(cfg_h)) && dim_ok(32'(cfg_w));
  assign hs        = bus.tile_req & bus.tile_ack;
  assign last_tile = (tr == tr_last) && (tc == tc_last);
  assign abort_hit = abort &&
                     ((state == S_LOADF) || (state == S_RUN) || (state == S_DRAIN));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = cfg_good ? S_LOADF : S_DONE;
      S_LOADF: state_nxt = S_RUN;
      S_RUN:   if (hs && last_tile) state_nxt = S_DRAIN;
      // The final result is on out_vld once nothing is left behind it.
      S_DRAIN: if (!pend) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_hit) state_nxt = S_IDLE;
  end

  // Tile counters and layer configuration. A dimension D gives (D-2)/2 tiles,
  // so the last index is D/2 - 2.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tr      <= '0;
      tc      <= '0;
      tr_last <= '0;
      tc_last <= '0;
      err_q   <= 1'b0;
    end else if (state == S_IDLE && start) begin
      tr    <= '0;
      tc    <= '0;
      err_q <= ~cfg_good;
      if (cfg_good) begin
        tr_last <= (cfg_h >> 1) - DIMW'(2);
        tc_last <= (cfg_w >> 1) - DIMW'(2);
      end
    end else if (abort_hit) begin
      tr <= '0;
      tc <= '0;
    end else if (hs) begin
      if (tc == tc_last) begin
        tc <= '0;
        if (tr != tr_last) tr <= tr + DIMW'(1);
      end else begin
        tc <= tc + DIMW'(1);
      end
    end
  end

  assign bus.filt_ld  = (state == S_LOADF);
  assign bus.tile_req = (state == S_RUN);
  assign bus.tile_row = tr << 1;
  assign bus.tile_col = tc << 1;
  assign bus.kern_vld = hs;

  // Input-tile origin (2*tr, 2*tc) equals the output-tile origin, so the
  // tile coordinate travels unchanged through the latency line.
  wino_lat_pipe #(
    .DIMW (DIMW),
    .LAT  (KERN_LAT)
  ) u_pipe (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (abort_hit),
    .in_vld  (hs),
    .in_row  (bus.tile_row),
    .in_col  (bus.tile_col),
    .out_vld (bus.out_vld),
    .out_row (bus.out_row),
    .out_col (bus.out_col),
    .pend    (pend)
  );

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_wino_tile_sched.sv
// tb_wino_tile_sched -- randomized self-checking bench for wino_tile_sched.
// The reference model enumerates the tile list of each layer from H and W,
// predicts the cycle of every Y result (handshake cycle + KERN_LAT) in an
// expected queue, and derives the done cycle from the last handshake.
module tb_wino_tile_sched;
  import wino_pkg::*;

  localparam int DIMW = 8;
  localparam int K    = 3;
  localparam int W    = 32 + 2 * DIMW;   // {due cycle, row, col}
  localparam int MAXC = 2000;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [DIMW-1:0] cfg_h = '0;
  logic [DIMW-1:0] cfg_w = '0;
  logic            busy, done, err;
  state_t          dbg_state;

  wino_tile_sched_if #(.DIMW(DIMW)) bus ();

  wino_tile_sched #(.DIMW(DIMW), .KERN_LAT(K)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .cfg_h     (cfg_h),
    .cfg_w     (cfg_w),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, done, err, bus.filt_ld, bus.tile_req, bus.kern_vld, bus.out_vld,
                bus.tile_row, bus.tile_col, bus.out_row, bus.out_col});
  endfunction

  // ---------------- driver: one layer ----------------
  // ack_pct: probability of tile_ack per cycle; cycles gap_at..gap_at+gap_len-1
  // force tile_ack low; abort_at: cycle (start accept = 0) to pulse abort, -1 none.
  task automatic run_layer(input int h, input int w, input int ack_pct,
                           input int gap_at, input int gap_len, input int abort_at);
    int c, ti, nt, tr_n, tc_n, done_c, row, col;
    bit ok, exp_req;
    logic [W-1:0] e;
    exp_q.delete();
    ok   = (h % 2 == 0) && (h >= 4) && (w % 2 == 0) && (w >= 4);
    tr_n = ok ? h / 2 - 1 : 0;
    tc_n = ok ? w / 2 - 1 : 0;
    nt   = tr_n * tc_n;

    @(negedge clk);
    chk("idle_busy", busy, 0);
    start = 1'b1;
    cfg_h = DIMW'(h);
    cfg_w = DIMW'(w);
    @(negedge clk);
    start = 1'b0;
    #1;
    if (!ok) begin
      chk("err_done", done, 1);
      chk("err_flag", err, 1);
      chk("err_filt_ld", bus.filt_ld, 0);
      chk("err_tile_req", bus.tile_req, 0);
      @(negedge clk);
      #1;
      chk("err_idle", busy, 0);
      chk("err_done_once", done, 0);
      chk("err_sticky", err, 1);
      return;
    end
    chk("filt_ld", bus.filt_ld, 1);
    chk("loadf_state", dbg_state, S_LOADF);
    chk("err_cleared", err, 0);
    chk("loadf_req", bus.tile_req, 0);
    chk("loadf_done", done, 0);

    c      = 1;
    ti     = 0;
    done_c = -1;
    while (c < MAXC) begin
      @(negedge clk);
      c++;
      if (gap_len > 0 && c >= gap_at && c < gap_at + gap_len) bus.tile_ack = 1'b0;
      else bus.tile_ack = ($urandom_range(1, 100) <= ack_pct);
      abort = (c == abort_at);
      start = ($urandom_range(0, 7) == 0);   // must be ignored while busy
      cfg_h = DIMW'($urandom);
      cfg_w = DIMW'($urandom);
      #1;
      if (exp_q.size() > 0 && exp_q[0][W-1:2*DIMW] == 32'(c)) begin
        e = exp_q.pop_front();
        chk("out_vld", bus.out_vld, 1);
        chk("out_row", bus.out_row, e[2*DIMW-1:DIMW]);
        chk("out_col", bus.out_col, e[DIMW-1:0]);
      end else begin
        chk("out_vld_quiet", bus.out_vld, 0);
      end
      chk("done", done, (c == done_c));
      chk("busy", busy, 1);
      chk("err_low", err, 0);
      if (c == done_c) break;
      exp_req = (ti < nt);
      chk("tile_req", bus.tile_req, exp_req);
      chk("kern_vld", bus.kern_vld, exp_req && bus.tile_ack);
      if (exp_req) begin
        row = 2 * (ti / tc_n);
        col = 2 * (ti % tc_n);
        chk("tile_row", bus.tile_row, row);
        chk("tile_col", bus.tile_col, col);
        if (bus.tile_ack) begin
          exp_q.push_back({32'(c + K), DIMW'(row), DIMW'(col)});
          ti++;
          if (ti == nt) done_c = c + K + 1;
        end
      end
      if (abort) begin
        exp_q.delete();
        repeat (K + 2) begin
          @(negedge clk);
          start        = 1'b0;
          abort        = 1'b0;
          bus.tile_ack = 1'($urandom_range(0, 1));
          #1;
          chk("abort_idle", busy, 0);
          chk("abort_no_out", bus.out_vld, 0);
          chk("abort_no_done", done, 0);
        end
        return;
      end
    end
    if (c >= MAXC) chk("layer_timeout", 0, 1);

    @(negedge clk);
    start        = 1'b0;
    abort        = 1'b0;
    bus.tile_ack = 1'b0;
    #1;
    chk("end_idle", busy, 0);
    chk("end_done_once", done, 0);
    chk("end_out_quiet", bus.out_vld, 0);
    chk("end_queue_empty", exp_q.size(), 0);
  endtask

  // Reset pulsed asynchronously in the middle of a running layer.
  task automatic reset_mid_run();
    @(negedge clk);
    start = 1'b1;
    cfg_h = DIMW'(8);
    cfg_w = DIMW'(8);
    @(negedge clk);
    start        = 1'b0;
    bus.tile_ack = 1'b1;
    repeat (4) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_outs_zero", all_outs(), 0);
    chk("rst_state", dbg_state, S_IDLE);
    @(negedge clk);
    #1;
    chk("rst_outs_hold", all_outs(), 0);
    #2 rstn = 1'b1;
    bus.tile_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_waits_idle", busy, 0);
    chk("rst_no_tile_req", bus.tile_req, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.tile_ack = 1'b0;
    #12;
    chk("reset_outs", all_outs(), 0);
    chk("reset_state", dbg_state, S_IDLE);
    @(negedge clk);
    rstn = 1'b1;

    run_layer(4, 4, 100, 0, 0, -1);     // single tile
    run_layer(6, 8, 100, 0, 0, -1);     // six back-to-back tiles
    run_layer(6, 6, 100, 3, 3, -1);     // ack gap after the first tile
    run_layer(8, 5, 100, 0, 0, -1);     // odd width -> config error
    run_layer(4, 4, 100, 0, 0, -1);     // error cleared by a good start
    run_layer(2, 6, 100, 0, 0, -1);     // height below one tile
    run_layer(4, 6, 100, 0, 0, 4);      // abort in DRAIN, two results in flight
    run_layer(10, 10, 70, 0, 0, 9);     // abort mid-RUN
    run_layer(8, 8, 100, 0, 0, 1);      // abort pulse not reached in loop (LOADF is cycle 1): full layer

    for (int i = 0; i < 14; i++) begin
      int h, w, ap, ab;
      h  = $urandom_range(2, 14);
      w  = $urandom_range(2, 14);
      ap = $urandom_range(30, 100);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : -1;
      run_layer(h, w, ap, 0, 0, ab);
    end

    reset_mid_run();
    run_layer(6, 6, 100, 0, 0, -1);     // full layer from (0,0) after reset
    run_layer(12, 8, 60, 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound in case a wait never returns.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
